dynamic_clock_divider_mc: RTL
=============================

# dynamic_clock_divider_mc

Multi-channel, parametrised successor to the single-channel dynamic clock divider. Each of CHANNELS independent channels generates a one-cycle clock-enable pulse every D enabled cycles of the shared system clock, where D is a per-channel runtime divisor of WIDTH bits. Divisor changes are double-buffered and take effect only at a period boundary, so no short or long periods appear. Sits between control/CSR logic and any downstream logic that needs divided-rate strobes.

## Interface
- CHANNELS, 4, number of independent divider channels (>=1)
- WIDTH, 16, divisor and counter width per channel (>=2)
- DEFAULT_DIV, 1, active divisor loaded into every channel at reset
- i_CLK  in  1  system clock, all logic on rising edge
- i_RESET  in  1  asynchronous, active-high reset
- i_ENABLE  in  CHANNELS  per-channel count enable
- i_DIV_VALUE  in  CHANNELS*WIDTH  channel k divisor at [k*WIDTH +: WIDTH]
- i_LOAD  in  CHANNELS  per-channel request to capture i_DIV_VALUE slice
- o_ENABLE_OUT  out  CHANNELS  one-cycle divided-rate strobe per channel
- o_LOAD_ACK  out  CHANNELS  one-cycle pulse when new divisor becomes active
- o_TOGGLE  out  CHANNELS  square-wave output (only with DCD_TOGGLE_EN)

## Operation
- Per channel: active divisor r_Div, shadow r_Shadow, flag r_Pending, counter r_Count (all WIDTH bits except flag).
- Effective divisor E = max(r_Div, 1); divisors 0 and 1 both mean divide-by-1.
- Enabled, r_Count == E-1: r_Count <= 0, o_ENABLE_OUT <= 1 (terminal edge).
- Enabled, otherwise: r_Count <= r_Count+1, o_ENABLE_OUT <= 0.
- Disabled: r_Count holds, o_ENABLE_OUT <= 0.
- i_LOAD high: r_Shadow <= slice, r_Pending <= 1. Repeated loads while pending overwrite r_Shadow; only the last value is adopted; one ack only.
- Adoption (r_Div <= shadow, r_Pending <= 0, r_Count <= 0, o_LOAD_ACK <= 1) happens on a terminal edge or on any edge with i_ENABLE low.
- i_LOAD coinciding with an adoption edge: slice bypasses the shadow and is adopted that same edge.
- Channels fully independent; no cross-channel interaction.

## Timing
- Reset values: o_ENABLE_OUT=0, o_LOAD_ACK=0, o_TOGGLE=0, r_Count=0, r_Div=DEFAULT_DIV, r_Pending=0.
- All outputs registered; no combinational input-to-output path.
- Enable asserted before edge 1 with E=D: first strobe visible after edge D, then every D edges.
- E=1: o_ENABLE_OUT high on every enabled cycle, continuous.
- Strobe on terminal edge and o_LOAD_ACK are asserted in the same cycle when adoption occurs at a wrap; the next period uses the new divisor.
- Disabled adoption: o_LOAD_ACK pulses one cycle after the loading edge; no strobe.
- Reset mid-period discards count, pending load and shadow; outputs clear immediately (asynchronous).
- r_Count never exceeds E-1 since r_Div changes only with r_Count cleared.

## Configuration
- DCD_TOGGLE_EN defined: o_TOGGLE present; each channel flips o_TOGGLE on every edge where it asserts o_ENABLE_OUT, giving a 50%-duty square wave of period 2*E cycles; for E=1 toggles every enabled cycle. Cleared by reset, holds while disabled, not cleared on adoption.
- Not defined: o_TOGGLE port and its flops absent; all other behaviour identical.

## Test plan
- Reset, ch0 load 4 while disabled, then enable -> ack one cycle after load; strobes after edges 4, 8, 12 of enabling.
- Ch1 running D=3, load 5 mid-period (count=1) -> period completes at 3, strobe+ack same cycle, next strobes every 5.
- Load 0 and load 1 on two channels -> both strobe every enabled cycle.
- Three back-to-back loads 7, 9, 2 while D=6 running -> single ack at wrap, new period length 2.
- Assert i_RESET asynchronously mid-period with pending load -> outputs 0 immediately; after release, divisor DEFAULT_DIV, no ack.
- DCD_TOGGLE_EN, D=3 -> o_TOGGLE period 6 cycles, flips coincident with strobes; without macro, port absent, build clean.

Source files
------------

// File: rtl/dynamic_clock_divider_mc_if.sv
// Control/strobe bundle for dynamic_clock_divider_mc.
// o_TOGGLE exists only when DCD_TOGGLE_EN is defined.
interface dynamic_clock_divider_mc_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  logic [CHANNELS-1:0]       i_ENABLE;
  logic [CHANNELS*WIDTH-1:0] i_DIV_VALUE;
  logic [CHANNELS-1:0]       i_LOAD;
  logic [CHANNELS-1:0]       o_ENABLE_OUT;
  logic [CHANNELS-1:0]       o_LOAD_ACK;
`ifdef DCD_TOGGLE_EN
  logic [CHANNELS-1:0]       o_TOGGLE;
`endif

  modport master (
    output i_ENABLE,
    output i_DIV_VALUE,
    output i_LOAD,
    input  o_ENABLE_OUT,
`ifdef DCD_TOGGLE_EN
    input  o_TOGGLE,
`endif
    input  o_LOAD_ACK
  );

  modport slave (
    input  i_ENABLE,
    input  i_DIV_VALUE,
    input  i_LOAD,
    output o_ENABLE_OUT,
`ifdef DCD_TOGGLE_EN
    output o_TOGGLE,
`endif
    output o_LOAD_ACK
  );
endinterface

// File: rtl/dynamic_clock_divider_mc.sv
// Multi-channel divided-rate strobe generator with period-boundary divisor adoption.
// Optional square-wave output per channel: define DCD_TOGGLE_EN.
module dynamic_clock_divider_mc #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET,
  dynamic_clock_divider_mc_if.slave    bus
);

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0] r_div;
      logic [WIDTH-1:0] r_shadow;
      logic [WIDTH-1:0] r_count;
      logic             r_pending;
      logic             r_strobe;
      logic             r_ack;

      logic [WIDTH-1:0] w_slice;
      logic [WIDTH-1:0] w_eff;
      logic             w_en;
      logic             w_load;
      logic             w_term;
      logic             w_adopt;

      assign w_en    = bus.i_ENABLE[k];
      assign w_load  = bus.i_LOAD[k];
      assign w_slice = bus.i_DIV_VALUE[k*WIDTH +: WIDTH];
      // Divisors 0 and 1 both collapse to divide-by-1.
      assign w_eff   = (r_div > WIDTH'(1)) ? r_div : WIDTH'(1);
      assign w_term  = w_en && (r_count == (w_eff - WIDTH'(1)));
      // A load arriving on an adoption edge bypasses the shadow register.
      assign w_adopt = (r_pending || w_load) && (w_term || !w_en);

      always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
          r_div     <= WIDTH'(DEFAULT_DIV);
          r_shadow  <= '0;
          r_count   <= '0;
          r_pending <= 1'b0;
          r_strobe  <= 1'b0;
          r_ack     <= 1'b0;
        end else begin
          r_strobe <= w_term;
          r_ack    <= w_adopt;
          if (w_adopt) begin
            r_div     <= w_load ? w_slice : r_shadow;
            r_pending <= 1'b0;
            r_count   <= '0;
          end else begin
            if (w_load) begin
              r_shadow  <= w_slice;
              r_pending <= 1'b1;
            end else begin
              r_pending <= r_pending;
            end
            if (w_term) begin
              r_count <= '0;
            end else if (w_en) begin
              r_count <= r_count + WIDTH'(1);
            end else begin
              r_count <= r_count;
            end
          end
        end
      end

      assign bus.o_ENABLE_OUT[k] = r_strobe;
      assign bus.o_LOAD_ACK[k]   = r_ack;

`ifdef DCD_TOGGLE_EN
      logic r_toggle;

      // Flips on every strobe edge; survives adoption so the wave stays continuous.
      always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
          r_toggle <= 1'b0;
        end else if (w_term) begin
          r_toggle <= ~r_toggle;
        end else begin
          r_toggle <= r_toggle;
        end
      end

      assign bus.o_TOGGLE[k] = r_toggle;
`endif
    end
  endgenerate

endmodule
